// File: rtl/dc_frame_packer.sv
// Serialises DC-register frames (header + payload) and launch packets (marker + command words)
// into a 32-bit command FIFO write port, one word per cycle while the FIFO has room.
module dc_frame_packer #(
  parameter int DAC_CHANNEL  = 24,
  parameter int FRAME_WORDS  = 62,
  parameter int LAUNCH_WORDS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_frame_valid,
  output logic                        o_frame_ready,
  input  logic [4:0]                  i_frame_chan,
  input  logic [7:0]                  i_frame_tag,
  input  logic [FRAME_WORDS*32-1:0]   i_frame_words,
  input  logic                        i_launch_valid,
  output logic                        o_launch_ready,
  input  logic [LAUNCH_WORDS*32-1:0]  i_launch_words,
  output logic [31:0]                 o_fifo_data,
  output logic                        o_fifo_wr,
  input  logic                        i_fifo_full,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_launch_done,
  output logic                        o_err_chan
);
  localparam int CW  = $clog2(FRAME_WORDS);
  localparam int LIW = (LAUNCH_WORDS > 1) ? $clog2(LAUNCH_WORDS) : 1;
  localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] LAUNCH_LAST = CW'(LAUNCH_WORDS - 1);

  typedef enum logic [2:0] {IDLE, L_HDR, L_BODY, F_HDR, F_BODY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   frame_buf  [FRAME_WORDS];
  logic [31:0]   launch_buf [LAUNCH_WORDS];
  logic          err_q;
  logic          frame_acc, launch_acc, chan_ok;
  logic [31:0]   hdr;

  // Payload word 0 is replaced by the generated header, so its input bits are intentionally dropped.
  logic unused_word0;
  assign unused_word0 = ^i_frame_words[31:0];

  always_comb begin
    chan_ok  = int'(i_frame_chan) < DAC_CHANNEL;
    hdr      = 32'hFFFF_FFFF;
    hdr[7:0] = i_frame_tag;
    for (int i = 0; i < DAC_CHANNEL; i++) begin
      if (int'(i_frame_chan) == i) hdr[8+i] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Buffers capture the request at the accept edge; the header is stored in slot 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
      for (int k = 0; k < FRAME_WORDS; k++) frame_buf[k] <= '0;
      for (int k = 0; k < LAUNCH_WORDS; k++) launch_buf[k] <= '0;
    end else begin
      err_q <= frame_acc && !chan_ok;
      if (frame_acc && chan_ok) begin
        frame_buf[0] <= hdr;
        for (int k = 1; k < FRAME_WORDS; k++) frame_buf[k] <= i_frame_words[k*32 +: 32];
      end
      if (launch_acc) begin
        for (int k = 0; k < LAUNCH_WORDS; k++) launch_buf[k] <= i_launch_words[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    o_fifo_wr      = 1'b0;
    o_fifo_data    = '0;
    o_frame_done   = 1'b0;
    o_launch_done  = 1'b0;
    o_launch_ready = (state == IDLE);
    o_frame_ready  = (state == IDLE) && !i_launch_valid;
    launch_acc     = i_launch_valid && o_launch_ready;
    frame_acc      = i_frame_valid && o_frame_ready;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (launch_acc) state_nxt = L_HDR;
        else if (frame_acc && chan_ok) state_nxt = F_HDR;
      end
      L_HDR: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = 32'hFFFF_FFFF;
        if (o_fifo_wr) state_nxt = L_BODY;
      end
      L_BODY: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = launch_buf[cnt[LIW-1:0]];
        if (o_fifo_wr) begin
          if (cnt == LAUNCH_LAST) begin
            o_launch_done = 1'b1;
            state_nxt     = IDLE;
            cnt_nxt       = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      F_HDR: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = frame_buf[cnt];
        if (o_fifo_wr) begin
          state_nxt = F_BODY;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      F_BODY: begin
        o_fifo_wr   = !i_fifo_full;
        o_fifo_data = frame_buf[cnt];
        if (o_fifo_wr) begin
          if (cnt == FRAME_LAST) begin
            o_frame_done = 1'b1;
            state_nxt    = IDLE;
            cnt_nxt      = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (state != IDLE);
  assign o_err_chan = err_q;
endmodule

// File: tb/tb_dc_frame_packer.sv
// Randomised bench for dc_frame_packer; expected FIFO streams come from a packet-level reference model.
module tb_dc_frame_packer;
  localparam int FW = 62;
  localparam int LW = 4;
  localparam int NC = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_valid = 1'b0;
  logic              frame_ready;
  logic [4:0]        frame_chan = '0;
  logic [7:0]        frame_tag = '0;
  logic [FW*32-1:0]  frame_words = '0;
  logic              launch_valid = 1'b0;
  logic              launch_ready;
  logic [LW*32-1:0]  launch_words = '0;
  logic [31:0]       fifo_data;
  logic              fifo_wr;
  logic              fifo_full = 1'b0;
  logic              busy, frame_done, launch_done, err_chan;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_full = 1'b0;

  logic [31:0] got[$];
  logic [31:0] exp[$];
  int fdone[$];
  int ldone[$];
  int fdone_cyc, first_cyc, err_cyc, acc_cyc;
  int err_cnt, stall_err;
  bit busy_seen, stall_prev;
  logic [31:0] data_prev;

  dc_frame_packer #(.DAC_CHANNEL(NC), .FRAME_WORDS(FW), .LAUNCH_WORDS(LW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_frame_valid(frame_valid), .o_frame_ready(frame_ready),
    .i_frame_chan(frame_chan), .i_frame_tag(frame_tag), .i_frame_words(frame_words),
    .i_launch_valid(launch_valid), .o_launch_ready(launch_ready), .i_launch_words(launch_words),
    .o_fifo_data(fifo_data), .o_fifo_wr(fifo_wr), .i_fifo_full(fifo_full),
    .o_busy(busy), .o_frame_done(frame_done), .o_launch_done(launch_done), .o_err_chan(err_chan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_full) begin
      #1;
      fifo_full = ($urandom_range(0, 2) == 0);
    end
  end

  always @(negedge clk) begin
    if (fifo_wr) begin
      if (got.size() == 0) first_cyc = cyc;
      got.push_back(fifo_data);
    end
    if (frame_done) begin
      fdone.push_back(got.size());
      fdone_cyc = cyc;
    end
    if (launch_done) ldone.push_back(got.size());
    if (err_chan) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (stall_prev && busy && fifo_data !== data_prev) stall_err++;
    stall_prev = busy && fifo_full;
    data_prev  = fifo_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=hang required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and stimulus helpers ----------------
  function automatic void model_frame(input logic [4:0] ch, input logic [7:0] tg,
                                      input logic [FW*32-1:0] w);
    exp.push_back({~(24'd1 << ch), tg});
    for (int k = 1; k < FW; k++) exp.push_back(w[k*32 +: 32]);
  endfunction

  function automatic void model_launch(input logic [LW*32-1:0] w);
    exp.push_back(32'hFFFF_FFFF);
    for (int k = 0; k < LW; k++) exp.push_back(w[k*32 +: 32]);
  endfunction

  task automatic clear_mon();
    got.delete(); fdone.delete(); ldone.delete(); exp.delete();
    err_cnt = 0; stall_err = 0; busy_seen = 1'b0;
    first_cyc = -1; fdone_cyc = -1; err_cyc = -1;
  endtask

  task automatic rand_fw(output logic [FW*32-1:0] w);
    for (int k = 0; k < FW; k++) w[k*32 +: 32] = $urandom;
  endtask

  task automatic rand_lw(output logic [LW*32-1:0] w);
    for (int k = 0; k < LW; k++) w[k*32 +: 32] = $urandom;
  endtask

  task automatic req_frame(input logic [4:0] ch, input logic [7:0] tg,
                           input logic [FW*32-1:0] w, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    frame_chan = ch; frame_tag = tg; frame_words = w; frame_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (frame_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    frame_valid = 1'b0; frame_words = ~w; frame_chan = ~ch; frame_tag = ~tg;
  endtask

  task automatic req_launch(input logic [LW*32-1:0] w, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    launch_words = w; launch_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (launch_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    launch_valid = 1'b0; launch_words = ~w;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    ok = (got.size() >= n);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr actual=%b required=0", fifo_wr); end
    checks++; if (fifo_data !== 32'h0) begin failures++; $display("FAIL reset_data actual=%h required=0", fifo_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if ({frame_done, launch_done, err_chan} !== 3'b000) begin failures++; $display("FAIL reset_pulses actual=%b required=000", {frame_done, launch_done, err_chan}); end
    checks++; if ({frame_ready, launch_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready actual=%b required=11", {frame_ready, launch_ready}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy actual=%b required=0", busy); end
  endtask

  task automatic test_frame_basic();
    logic [FW*32-1:0] w;
    bit ok;
    clear_mon();
    for (int k = 0; k < FW; k++) w[k*32 +: 32] = k;
    model_frame(5'd5, 8'hA5, w);
    req_frame(5'd5, 8'hA5, w, ok);
    checks++; if (!ok) begin failures++; $display("FAIL frame_accept actual=timeout required=accepted"); end
    wait_words(FW, 300, ok);
    checks++; if (got.size() != FW) begin failures++; $display("FAIL frame_count actual=%0d required=%0d", got.size(), FW); end
    checks++; if (got[0] !== 32'hFFFFDFA5) begin failures++; $display("FAIL frame_header actual=%h required=ffffdfa5", got[0]); end
    for (int i = 0; i < FW; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL frame_word[%0d] actual=%h required=%h", i, got[i], exp[i]); end
    end
    checks++; if (fdone.size() != 1 || fdone[0] != FW) begin failures++; $display("FAIL frame_done_pos actual=%0d pulses required=1 at word %0d", fdone.size(), FW); end
    checks++; if (first_cyc != acc_cyc) begin failures++; $display("FAIL frame_latency actual=%0d required=%0d", first_cyc, acc_cyc); end
    checks++; if (fdone_cyc != acc_cyc + FW - 1) begin failures++; $display("FAIL frame_duration actual=%0d required=%0d", fdone_cyc, acc_cyc + FW - 1); end
  endtask

  task automatic test_launch();
    logic [LW*32-1:0] w;
    bit ok;
    clear_mon();
    w = {32'h44, 32'h33, 32'h22, 32'h11};
    model_launch(w);
    req_launch(w, ok);
    checks++; if (!ok) begin failures++; $display("FAIL launch_accept actual=timeout required=accepted"); end
    wait_words(LW + 1, 50, ok);
    checks++; if (got.size() != LW + 1) begin failures++; $display("FAIL launch_count actual=%0d required=%0d", got.size(), LW + 1); end
    for (int i = 0; i < LW + 1; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL launch_word[%0d] actual=%h required=%h", i, got[i], exp[i]); end
    end
    checks++; if (ldone.size() != 1 || ldone[0] != LW + 1) begin failures++; $display("FAIL launch_done_pos actual=%0d pulses required=1 at word %0d", ldone.size(), LW + 1); end
    checks++; if (first_cyc != acc_cyc) begin failures++; $display("FAIL launch_latency actual=%0d required=%0d", first_cyc, acc_cyc); end
  endtask

  task automatic test_priority();
    logic [FW*32-1:0] w;
    logic [LW*32-1:0] lw;
    logic [4:0] ch;
    logic [7:0] tg;
    bit ok;
    clear_mon();
    rand_fw(w); rand_lw(lw);
    ch = 5'($urandom_range(0, NC - 1)); tg = 8'($urandom);
    model_launch(lw); model_frame(ch, tg, w);
    @(posedge clk); #1;
    frame_chan = ch; frame_tag = tg; frame_words = w; frame_valid = 1'b1;
    launch_words = lw; launch_valid = 1'b1;
    @(negedge clk);
    checks++; if ({launch_ready, frame_ready} !== 2'b10) begin failures++; $display("FAIL prio_ready actual=%b required=10", {launch_ready, frame_ready}); end
    @(posedge clk); #1;
    launch_valid = 1'b0; launch_words = ~lw;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (frame_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    frame_valid = 1'b0; frame_words = ~w;
    checks++; if (!ok) begin failures++; $display("FAIL prio_frame_accept actual=timeout required=accepted"); end
    wait_words(LW + 1 + FW, 300, ok);
    checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL prio_count actual=%0d required=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL prio_word[%0d] actual=%h required=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_full_stall();
    logic [FW*32-1:0] w;
    logic [4:0] ch;
    bit ok, stalled;
    clear_mon();
    rand_fw(w);
    ch = 5'($urandom_range(0, NC - 1));
    model_frame(ch, 8'h3C, w);
    req_frame(ch, 8'h3C, w, ok);
    stalled = 1'b0;
    for (int n = 0; n < 300 && got.size() < FW; n++) begin
      if (!stalled && got.size() == 11) begin
        stalled = 1'b1;
        fifo_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL stall_wr actual=%b required=0", fifo_wr); end
          checks++; if (fifo_data !== exp[11]) begin failures++; $display("FAIL stall_data actual=%h required=%h", fifo_data, exp[11]); end
          @(posedge clk); #1;
        end
        fifo_full = 1'b0;
      end
      @(posedge clk); #1;
    end
    wait_words(FW, 50, ok);
    checks++; if (!stalled) begin failures++; $display("FAIL stall_reached actual=%0d words required=11", got.size()); end
    checks++; if (got.size() != FW) begin failures++; $display("FAIL stall_count actual=%0d required=%0d", got.size(), FW); end
    for (int i = 0; i < FW; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL stall_word[%0d] actual=%h required=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [FW*32-1:0] w;
    logic [LW*32-1:0] lw;
    logic [4:0] ch;
    logic [7:0] tg;
    bit ok;
    clear_mon();
    rand_full = 1'b1;
    for (int p = 0; p < 4; p++) begin
      if (p % 2 == 0) begin
        rand_fw(w); ch = 5'($urandom_range(0, NC - 1)); tg = 8'($urandom);
        model_frame(ch, tg, w);
        req_frame(ch, tg, w, ok);
      end else begin
        rand_lw(lw);
        model_launch(lw);
        req_launch(lw, ok);
      end
      checks++; if (!ok) begin failures++; $display("FAIL b2b_accept[%0d] actual=timeout required=accepted", p); end
    end
    wait_words(exp.size(), 2000, ok);
    rand_full = 1'b0;
    @(posedge clk); #2;
    fifo_full = 1'b0;
    checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL b2b_count actual=%0d required=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL b2b_word[%0d] actual=%h required=%h", i, got[i], exp[i]); end
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL b2b_stall_stable actual=%0d changes required=0", stall_err); end
    checks++; if (fdone.size() != 2 || ldone.size() != 2) begin failures++; $display("FAIL b2b_done actual=%0d/%0d required=2/2", fdone.size(), ldone.size()); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL b2b_err actual=%0d required=0", err_cnt); end
  endtask

  task automatic test_bad_chan();
    logic [FW*32-1:0] w;
    logic [4:0] ch;
    bit ok;
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      rand_fw(w);
      ch = (t == 0) ? 5'(NC) : 5'($urandom_range(NC, 31));
      req_frame(ch, 8'($urandom), w, ok);
      repeat (5) begin @(posedge clk); #1; end
      checks++; if (!ok) begin failures++; $display("FAIL badchan_accept[%0d] actual=timeout required=accepted", ch); end
      checks++; if (err_cnt != 1) begin failures++; $display("FAIL badchan_err[%0d] actual=%0d required=1", ch, err_cnt); end
      checks++; if (err_cyc != acc_cyc) begin failures++; $display("FAIL badchan_err_time[%0d] actual=%0d required=%0d", ch, err_cyc, acc_cyc); end
      checks++; if (got.size() != 0) begin failures++; $display("FAIL badchan_writes[%0d] actual=%0d required=0", ch, got.size()); end
      checks++; if (busy_seen) begin failures++; $display("FAIL badchan_busy[%0d] actual=1 required=0", ch); end
    end
  endtask

  task automatic test_reset_mid();
    logic [FW*32-1:0] w;
    logic [4:0] ch;
    bit ok;
    clear_mon();
    rand_fw(w);
    ch = 5'($urandom_range(0, NC - 1));
    req_frame(ch, 8'h77, w, ok);
    for (int n = 0; n < 200 && got.size() < 30; n++) begin @(posedge clk); #1; end
    checks++; if (fifo_wr !== 1'b1) begin failures++; $display("FAIL midrst_pre_wr actual=%b required=1", fifo_wr); end
    #1 rst = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL midrst_wr actual=%b required=0", fifo_wr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy actual=%b required=0", busy); end
    @(negedge clk); rst = 1'b0;
    clear_mon();
    rand_fw(w);
    ch = 5'($urandom_range(0, NC - 1));
    model_frame(ch, 8'h5A, w);
    req_frame(ch, 8'h5A, w, ok);
    wait_words(FW, 300, ok);
    checks++; if (got.size() != FW) begin failures++; $display("FAIL midrst_count actual=%0d required=%0d", got.size(), FW); end
    for (int i = 0; i < FW; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL midrst_word[%0d] actual=%h required=%h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_launch();
    test_priority();
    test_full_stall();
    test_back_to_back();
    test_bad_chan();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
